// File: rtl/fma16_pkg.sv
// ----------------------------------------------------------------------------
// fma16_pkg : opcode/rounding enums, canonical NaN and op decode for fma16_issue
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'b000,
    OP_FSUB    = 3'b001,
    OP_FMUL    = 3'b010,
    OP_FMADD   = 3'b011,
    OP_FMSUB   = 3'b100,
    OP_FNMADD  = 3'b101,
    OP_FNMSUB  = 3'b110,
    OP_ILLEGAL = 3'b111
  } fma_op_e;

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RP  = 2'b10,
    RM_RN  = 2'b11
  } fma_rm_e;

  localparam logic [15:0] QNAN16 = 16'h7E00;

  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } fma_ctl_t;

  function automatic fma_ctl_t decode_op(input logic [2:0] op);
    fma_ctl_t ctl;
    case (op)
      OP_FADD:   ctl = 4'b0100;
      OP_FSUB:   ctl = 4'b0101;
      OP_FMUL:   ctl = 4'b1000;
      OP_FMADD:  ctl = 4'b1100;
      OP_FMSUB:  ctl = 4'b1101;
      OP_FNMADD: ctl = 4'b1110;
      OP_FNMSUB: ctl = 4'b1111;
      default:   ctl = 4'b0000;
    endcase
    return ctl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fma16_fifo2.sv
// ----------------------------------------------------------------------------
// fma16_fifo2 : 2-entry synchronous FIFO with occupancy count
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fma16_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign count   = cnt;

endmodule

`default_nettype wire

// File: rtl/fma16_issue.sv
// ----------------------------------------------------------------------------
// fma16_issue : queues fp16 FMA requests, drives an external fma16 datapath
//               from the queue head and registers the tagged response
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fma16_issue
  import fma16_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [1:0]      req_rm,
  input  logic [15:0]     req_x,
  input  logic [15:0]     req_y,
  input  logic [15:0]     req_z,
  input  logic [TAGW-1:0] req_tag,
  output logic [15:0]     fma_x,
  output logic [15:0]     fma_y,
  output logic [15:0]     fma_z,
  output logic            fma_mul,
  output logic            fma_add,
  output logic            fma_negr,
  output logic            fma_negz,
  output logic [1:0]      fma_roundmode,
  input  logic [15:0]     fma_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_result,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      rm;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [15:0]     z;
    logic [TAGW-1:0] tag;
  } req_t;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_state_e;

  req_t       in_req;
  req_t       head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       head_valid;
  logic       push;
  logic       capture;
  logic       head_illegal;
  fma_ctl_t   ctl;
  rsp_state_e state_q;
  rsp_state_e state_d;

  assign in_req = '{op: req_op, rm: req_rm, x: req_x, y: req_y, z: req_z, tag: req_tag};

  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;

  fma16_fifo2 #(
    .WIDTH($bits(req_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (in_req),
    .pop     (capture),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (occupancy)
  );

  assign head_valid   = ~fifo_empty;
  assign head_illegal = (head.op == OP_ILLEGAL);

  // Datapath sees all-zero inputs whenever nothing is queued.
  assign ctl           = head_valid ? decode_op(head.op) : '0;
  assign fma_x         = head_valid ? head.x  : '0;
  assign fma_y         = head_valid ? head.y  : '0;
  assign fma_z         = head_valid ? head.z  : '0;
  assign fma_roundmode = head_valid ? head.rm : '0;
  assign fma_mul       = ctl.mul;
  assign fma_add       = ctl.add;
  assign fma_negr      = ctl.negr;
  assign fma_negz      = ctl.negz;

  assign capture = head_valid & ((state_q == S_EMPTY) | rsp_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (capture) state_d = S_FULL;
      S_FULL:  if (rsp_ready && !capture) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (capture) begin
      rsp_result <= head_illegal ? QNAN16 : fma_result;
      rsp_tag    <= head.tag;
      rsp_err    <= head_illegal;
    end
  end

  assign rsp_valid = (state_q == S_FULL);

endmodule

`default_nettype wire

// File: tb/tb_fma16_issue.sv
// ----------------------------------------------------------------------------
// tb_fma16_issue : table-driven + scoreboard bench with a real-valued fma16 model
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fma16_issue;

  localparam int TAGW = 4;

  logic            clk;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [1:0]      req_rm;
  logic [15:0]     req_x, req_y, req_z;
  logic [TAGW-1:0] req_tag;
  logic [15:0]     fma_x, fma_y, fma_z;
  logic            fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]      fma_roundmode;
  logic [15:0]     fma_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_result;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;
  logic [1:0]      occupancy;

  fma16_issue #(.TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_tag(req_tag),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fp16 <-> real, exact for the small-integer operands used here
  function automatic real h2r(input logic [15:0] h);
    int  e;
    real v;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]);
      for (int i = 0; i < 24; i++) v = v / 2.0;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = 0; i < 31; i++) begin
        if (i < e - 15) v = v * 2.0;
        if (i < 15 - e) v = v / 2.0;
      end
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic       s;
    real        a;
    int         e;
    logic [9:0] m;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return 16'h0000;
    e = 15;
    for (int i = 0; i < 40; i++) begin
      if (a >= 2.0) begin a = a / 2.0; e++; end
      else if (a < 1.0) begin a = a * 2.0; e--; end
    end
    m = 10'($rtoi((a - 1.0) * 1024.0));
    return {s, 5'(e), m};
  endfunction

  function automatic logic [3:0] tb_ctl(input logic [2:0] op);
    case (op)
      3'b000:  return 4'b0100;
      3'b001:  return 4'b0101;
      3'b010:  return 4'b1000;
      3'b011:  return 4'b1100;
      3'b100:  return 4'b1101;
      3'b101:  return 4'b1110;
      3'b110:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // ctl = {mul, add, negr, negz}; negr negates the final result, negz negates z
  function automatic logic [15:0] fma_model(input logic [15:0] x, y, z, input logic [3:0] ctl);
    real p;
    p = ctl[3] ? h2r(x) * h2r(y) : h2r(x);
    if (ctl[2]) p = p + (ctl[0] ? -h2r(z) : h2r(z));
    if (ctl[1]) p = -p;
    return r2h(p);
  endfunction

  function automatic logic [15:0] exp_of(input logic [2:0] op, input logic [15:0] x, y, z);
    return (op == 3'b111) ? 16'h7E00 : fma_model(x, y, z, tb_ctl(op));
  endfunction

  assign fma_result = fma_model(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negr, fma_negz});

  typedef struct packed {
    logic [15:0]     res;
    logic [TAGW-1:0] tag;
    logic            err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   fires = 0;
  int   mark = 0;
  int   first_fire = 0;
  int   last_fire = 0;
  int   max_occ = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  always @(posedge clk) cyc++;

  // Response monitor / scoreboard pop
  always @(negedge clk) begin
    if (reset_n) begin
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (rsp_valid && rsp_ready) begin
        if (fires == mark) first_fire = cyc;
        last_fire = cyc;
        fires++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {rsp_result, rsp_tag, rsp_err}, 64'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp", {rsp_result, rsp_tag, rsp_err}, {e.res, e.tag, e.err});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [15:0] x, y, z,
                      input logic [TAGW-1:0] tag, input logic [15:0] eres, input logic eerr);
    rsp_t r;
    bit   ok;
    req_valid = 1'b1; req_op = op; req_rm = rm;
    req_x = x; req_y = y; req_z = z; req_tag = tag;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) begin
        r.res = eres; r.tag = tag; r.err = eerr;
        sb.push_back(r);
        ok = 1'b1;
      end
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [15:0] x, y, z;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e9;
    logic [2:0]  op;
    logic [15:0] a, b, c;

    tbl[0] = '{3'b011, 2'b01, 16'h4000, 16'h4200, 16'h3C00, 4'd3, 16'h4700, 1'b0};
    tbl[1] = '{3'b001, 2'b00, 16'h4200, 16'h5555, 16'h3C00, 4'd1, 16'h4000, 1'b0};
    tbl[2] = '{3'b101, 2'b10, 16'h4000, 16'h4200, 16'h3C00, 4'd2, 16'hC700, 1'b0};
    tbl[3] = '{3'b010, 2'b11, 16'h4000, 16'h4000, 16'h1234, 4'd4, 16'h4400, 1'b0};
    tbl[4] = '{3'b111, 2'b01, 16'h4000, 16'h4200, 16'h3C00, 4'd5, 16'h7E00, 1'b1};
    tbl[5] = '{3'b000, 2'b01, 16'h3C00, 16'h4400, 16'h4000, 4'd6, 16'h4200, 1'b0};
    tbl[6] = '{3'b100, 2'b10, 16'h4000, 16'h4200, 16'h3C00, 4'd7, 16'h4500, 1'b0};
    tbl[7] = '{3'b110, 2'b00, 16'h4000, 16'h4200, 16'h3C00, 4'd8, 16'hC500, 1'b0};

    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rm = '0;
    req_x = '0; req_y = '0; req_z = '0; req_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp", {rsp_valid, rsp_result, rsp_tag, rsp_err, occupancy, req_ready}, {1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 1'b1});
    chk("reset_fma", {fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode}, 0);

    // Table: one request at a time with rsp_ready high
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].op, tbl[i].rm, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].tag, tbl[i].res, tbl[i].err);
      req_valid = 1'b0;
      @(negedge clk);
      chk("head_decode", {fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode}, {tb_ctl(tbl[i].op), tbl[i].rm});
      chk("head_operands", {fma_x, fma_y, fma_z, rsp_valid}, {tbl[i].x, tbl[i].y, tbl[i].z, 1'b0});
      @(negedge clk);
      chk("latency_valid", rsp_valid, 1);
      @(posedge clk); #1;
    end
    chk("table_drained", sb.size(), 0);

    // Backpressure: three back-to-back pushes with rsp_ready low
    rsp_ready = 1'b0;
    e9 = exp_of(3'b000, 16'h3C00, 16'h0, 16'h4000);
    send(3'b000, 2'b01, 16'h3C00, 16'h0000, 16'h4000, 4'd9,  e9, 1'b0);
    send(3'b010, 2'b01, 16'h4200, 16'h4200, 16'h0000, 4'd10, exp_of(3'b010, 16'h4200, 16'h4200, 16'h0), 1'b0);
    send(3'b011, 2'b01, 16'h4000, 16'h4400, 16'h3C00, 4'd11, exp_of(3'b011, 16'h4000, 16'h4400, 16'h3C00), 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_full", {occupancy, req_ready, rsp_valid, rsp_tag}, {2'd2, 1'b0, 1'b1, 4'd9});
    repeat (3) @(negedge clk);
    chk("bp_hold", {rsp_valid, rsp_result, rsp_tag, rsp_err, occupancy}, {1'b1, e9, 4'd9, 1'b0, 2'd2});
    @(posedge clk); #1;
    mark = fires;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_release_count", fires - mark, 3);
    chk("bp_release_consec", last_fire - first_fire, 2);
    chk("bp_drained", sb.size(), 0);

    // Throughput: 8 back-to-back requests with rsp_ready high
    @(posedge clk); #1;
    mark = fires;
    max_occ = 0;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      a = r2h(real'($urandom_range(1, 4)));
      b = r2h(real'($urandom_range(1, 4)));
      c = r2h(real'($urandom_range(1, 4)));
      send(op, 2'($urandom_range(0, 3)), a, b, c, 4'(i), exp_of(op, a, b, c), op == 3'b111);
    end
    req_valid = 1'b0;
    drain();
    chk("tp_count", fires - mark, 8);
    chk("tp_consec", last_fire - first_fire, 7);
    chk("tp_occ_le1", max_occ <= 1, 1);

    // Reset with a full queue and a pending response
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(3'b000, 2'b00, 16'h3C00, 16'h0, 16'h3C00, 4'd12, exp_of(3'b000, 16'h3C00, 16'h0, 16'h3C00), 1'b0);
    send(3'b010, 2'b00, 16'h4000, 16'h4000, 16'h0, 4'd13, exp_of(3'b010, 16'h4000, 16'h4000, 16'h0), 1'b0);
    send(3'b011, 2'b00, 16'h4000, 16'h4000, 16'h3C00, 4'd14, exp_of(3'b011, 16'h4000, 16'h4000, 16'h3C00), 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_full", {occupancy, rsp_valid}, {2'd2, 1'b1});
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_rsp", {rsp_valid, rsp_result, rsp_tag, rsp_err, occupancy}, 0);
    chk("async_reset_fma", {fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {req_ready, occupancy, rsp_valid}, {1'b1, 2'd0, 1'b0});
    mark = fires;
    repeat (5) @(negedge clk);
    #1;
    chk("no_stale_rsp", fires - mark, 0);

    @(posedge clk); #1;
    send(3'b011, 2'b01, 16'h4000, 16'h4200, 16'h3C00, 4'd15, 16'h4700, 1'b0);
    req_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fma16_issue.md
FMA16_ISSUE -- requirements
Module: fma16_issue

Interface
REQ-001 SHALL have parameter TAGW, default 4, meaning request/response tag width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req_valid input 1 / req_ready output 1: request handshake.
REQ-005 SHALL have port req_op  input  3  opcode: 000 fadd, 001 fsub, 010 fmul, 011 fmadd, 100 fmsub, 101 fnmadd, 110 fnmsub, 111 illegal.
REQ-006 SHALL have port req_rm  input  2  rounding mode: 00 rz, 01 rne, 10 rp, 11 rn.
REQ-007 SHALL have ports req_x, req_y, req_z  input  16 each  fp16 operands.
REQ-008 SHALL have port req_tag  input  TAGW  opaque request ID.
REQ-009 SHALL have ports fma_x, fma_y, fma_z output 16; fma_mul, fma_add, fma_negr, fma_negz output 1; fma_roundmode output 2: drive the fma16 datapath.
REQ-010 SHALL have port fma_result  input  16  fma16 combinational result.
REQ-011 SHALL have ports rsp_valid output 1 / rsp_ready input 1: response handshake.
REQ-012 SHALL have ports rsp_result output 16, rsp_tag output TAGW, rsp_err output 1 (illegal opcode).
REQ-013 SHALL have port occupancy  output  2  queued requests (0..2) not yet in the response register.

Function
REQ-014 SHALL buffer accepted requests in a 2-entry FIFO; req_ready = (occupancy != 2), driven from registered state only.
REQ-015 SHALL accept a request on a rising edge with req_valid & req_ready; req_valid with req_ready low SHALL be ignored, with no state change.
REQ-016 SHALL drive fma_* combinationally from the FIFO head; all fma_* SHALL be 0 when the FIFO is empty.
REQ-017 SHALL decode the head op to {mul,add,negr,negz}: fadd 0100, fsub 0101, fmul 1000, fmadd 1100, fmsub 1101, fnmadd 1110, fnmsub 1111, illegal 0000.
REQ-018 Response register SHALL use a two-state machine, EMPTY/FULL; EMPTY->FULL on capture; FULL->EMPTY on rsp_ready with no capture; FULL->FULL on rsp_ready with simultaneous capture.
REQ-019 SHALL capture head (result, tag, err) and pop the FIFO in the same edge when the head is valid and (state EMPTY or rsp_ready=1).
REQ-020 For illegal op, capture SHALL load rsp_result=16'h7E00 and rsp_err=1, ignoring fma_result; otherwise rsp_result=fma_result, rsp_err=0.
REQ-021 Latency: request accepted on edge E SHALL give rsp_valid=1 after edge E+1 when the response path is free.
REQ-022 Throughput: one request per cycle sustained while rsp_ready stays 1.
REQ-023 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; push at occupancy 2 is impossible (ready low).
REQ-025 Responses SHALL return in acceptance order; no request dropped or duplicated.

Reset
REQ-026 reset_n low SHALL asynchronously clear the FIFO (occupancy 0), state EMPTY, rsp_valid 0, rsp_result 0, rsp_tag 0, rsp_err 0; req_ready SHALL be 1 while reset is deasserted and occupancy is 0.
REQ-027 Reset mid-operation SHALL discard all queued and pending responses; no response SHALL emerge after reset release without a new request.

Structure
REQ-028 Package fma16_pkg SHALL hold the opcode enum, the rounding-mode enum, the constant QNAN16=16'h7E00, and the decode function.
REQ-029 SHALL instantiate one sub-module, fma16_fifo2 (2-entry synchronous FIFO, parameterised width); fma16 itself is instantiated outside, by the parent.

Verification (bench connects a real fma16 or a golden model to fma_*)
REQ-030 fmadd x=4000 y=4200 z=3C00 rm=01 tag=3 -> next-cycle rsp_result=4700, rsp_tag=3, rsp_err=0.
REQ-031 fsub x=4200 z=3C00 -> 4000; fnmadd x=4000 y=4200 z=3C00 -> C700; fmul x=4000 y=4000 -> 4400.
REQ-032 op=111 tag=5 -> rsp_result=7E00, rsp_err=1, rsp_tag=5; fma_mul/add/negr/negz all 0 while it is head.
REQ-033 rsp_ready=0, push 3 requests back-to-back -> 1 in response register, occupancy=2, req_ready=0; release rsp_ready -> tags return in order, one per cycle.
REQ-034 Continuous req_valid and rsp_ready=1 for 8 requests -> 8 responses in 8 consecutive cycles, occupancy never exceeds 1.
REQ-035 Assert reset_n low with occupancy 2 and rsp_valid 1 -> all outputs zero immediately, req_ready=1 after release, no stale response.
